// File: rtl/setpoint_ctrl_pkg.sv
// Shared types and constants for the thermostat setpoint controller.
// Holds the controller state enum, the legal setpoint range and the step helper.
package setpoint_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_EDIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [6:0] SP_TEMP_MIN     = 7'd50;
  localparam logic [6:0] SP_TEMP_MAX     = 7'd90;
  localparam logic [6:0] SP_TEMP_DEFAULT = 7'd70;

  // One saturating step up or down inside [lo, hi]; never wraps.
  function automatic logic [6:0] step_temp(input logic [6:0] t, input logic inc,
                                           input logic [6:0] lo, input logic [6:0] hi);
    if (inc) return (t >= hi) ? hi : t + 7'd1;
    return (t <= lo) ? lo : t - 7'd1;
  endfunction

endpackage

// File: rtl/setpoint_ctrl_btn_debounce.sv
// Per-button front end: 2-flop synchronizer, stability debouncer, rising-edge
// press pulse and optional auto-repeat while the clean level stays high.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic        sync_q1, sync_q2;
  logic        clean, clean_q;
  logic [19:0] db_cnt;
  logic [23:0] rep_cnt;
  logic        press, repeat_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours (the synchronizer chain depends on it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      clean   <= 1'b0;
      clean_q <= 1'b0;
      db_cnt  <= '0;
      rep_cnt <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      clean_q <= clean;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES in a row.
      if (sync_q2 == clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        clean  <= sync_q2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end

      // Counts cycles since the press; release clears it.
      if (!clean)                          rep_cnt <= '0;
      else if (rep_cnt == REPEAT_CYCLES)   rep_cnt <= 24'd1;
      else                                 rep_cnt <= rep_cnt + 24'd1;
    end
  end

  assign press      = clean & ~clean_q;
  assign repeat_hit = REPEAT_EN && clean && (rep_cnt == REPEAT_CYCLES);
  assign pulse      = press | repeat_hit;

endmodule

// File: rtl/setpoint_ctrl.sv
// Setpoint controller: debounced buttons drive an OFF/EDIT/ACTIVE FSM that edits,
// commits or abandons a saturating 7-bit temperature setpoint.
module setpoint_ctrl
  import setpoint_ctrl_pkg::*;
#(
  parameter logic [6:0]  TEMP_MIN        = SP_TEMP_MIN,
  parameter logic [6:0]  TEMP_MAX        = SP_TEMP_MAX,
  parameter logic [6:0]  TEMP_DEFAULT    = SP_TEMP_DEFAULT,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000,
  parameter logic [27:0] TIMEOUT_CYCLES  = 28'd200000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_set,
  input  logic       btn_clear,
  output logic [6:0] desired_temp,
  output logic       temp_set,
  output logic [6:0] edit_temp,
  output logic       editing
);

  logic up_ev, down_ev, set_ev, clr_ev, any_ev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
    u_up    (.clk(clk), .reset(reset), .btn(btn_up),    .pulse(up_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
    u_down  (.clk(clk), .reset(reset), .btn(btn_down),  .pulse(down_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
    u_set   (.clk(clk), .reset(reset), .btn(btn_set),   .pulse(set_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
    u_clear (.clk(clk), .reset(reset), .btn(btn_clear), .pulse(clr_ev));

  assign any_ev = up_ev | down_ev | set_ev | clr_ev;

  state_t      state, state_n;
  logic        ret_active, ret_active_n;   // state to fall back to on timeout
  logic [27:0] timer, timer_n;
  logic [6:0]  desired_n, edit_n;
  logic        temp_set_n;

  // NOTE: every always_comb output is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    desired_n    = desired_temp;
    edit_n       = edit_temp;
    ret_active_n = ret_active;
    timer_n      = '0;

    unique case (state)
      ST_OFF, ST_ACTIVE: begin
        if (clr_ev) begin
          if (state == ST_ACTIVE) state_n = ST_OFF;
        end else if (!set_ev && (up_ev ^ down_ev)) begin
          // Entering EDIT only opens the editor; this event does not step.
          state_n      = ST_EDIT;
          ret_active_n = (state == ST_ACTIVE);
        end
      end
      ST_EDIT: begin
        timer_n = any_ev ? '0 : timer + 28'd1;
        if (clr_ev) begin
          state_n = ST_OFF;
        end else if (set_ev) begin
          desired_n = edit_temp;
          state_n   = ST_ACTIVE;
        end else if (up_ev ^ down_ev) begin
          edit_n = step_temp(edit_temp, up_ev, TEMP_MIN, TEMP_MAX);
        end else if (!any_ev && timer == TIMEOUT_CYCLES - 28'd1) begin
          state_n = ret_active ? ST_ACTIVE : ST_OFF;
        end
      end
      default: state_n = ST_OFF;
    endcase

    if (state_n != ST_EDIT) edit_n = desired_n;
    temp_set_n = (state_n == ST_ACTIVE) || (state_n == ST_EDIT && ret_active_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_OFF;
      ret_active   <= 1'b0;
      timer        <= '0;
      desired_temp <= TEMP_DEFAULT;
      edit_temp    <= TEMP_DEFAULT;
      temp_set     <= 1'b0;
      editing      <= 1'b0;
    end else begin
      state        <= state_n;
      ret_active   <= ret_active_n;
      timer        <= timer_n;
      desired_temp <= desired_n;
      edit_temp    <= edit_n;
      temp_set     <= temp_set_n;
      editing      <= (state_n == ST_EDIT);
    end
  end

endmodule

// File: doc/setpoint_ctrl.md
SETPOINT_CTRL -- requirements
Module: setpoint_ctrl

Interface
REQ-001 Parameter TEMP_MIN, default 7'd50: lowest legal setpoint.
REQ-002 Parameter TEMP_MAX, default 7'd90: highest legal setpoint.
REQ-003 Parameter TEMP_DEFAULT, default 7'd70: setpoint loaded at reset.
REQ-004 Parameter DEBOUNCE_CYCLES, default 20'd500000: number of consecutive stable cycles that accept a button level.
REQ-005 Parameter REPEAT_CYCLES, default 24'd5000000: auto-repeat period while up/down is held.
REQ-006 Parameter TIMEOUT_CYCLES, default 28'd200000000: number of idle cycles in EDIT that abandon the edit.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high.
REQ-009 btn_up  input  1  raw, asynchronous increment button.
REQ-010 btn_down  input  1  raw, asynchronous decrement button.
REQ-011 btn_set  input  1  raw, asynchronous commit button.
REQ-012 btn_clear  input  1  raw, asynchronous disable button.
REQ-013 desired_temp  output  7  committed setpoint, registered.
REQ-014 temp_set  output  1  high while a committed setpoint is active, registered.
REQ-015 edit_temp  output  7  working value for the display, registered.
REQ-016 editing  output  1  high in EDIT state, registered.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its clean level only after DEBOUNCE_CYCLES consecutive cycles of an unchanged synchronized level.
REQ-018 A press event SHALL be a 1-cycle pulse generated on the rising edge of a clean level.
REQ-019 While clean up or down stays high, an additional step event SHALL fire every REPEAT_CYCLES cycles after the press; release SHALL clear the repeat counter.
REQ-020 States SHALL be OFF, EDIT and ACTIVE; reset state is OFF.
REQ-021 OFF: temp_set=0; an up/down event SHALL enter EDIT with edit_temp=desired_temp; that first event SHALL NOT step the value.
REQ-022 ACTIVE: temp_set=1; an up/down event SHALL enter EDIT as in OFF; a clear event SHALL go to OFF.
REQ-023 EDIT: an up event SHALL increment edit_temp and a down event SHALL decrement it, one per event, saturating at TEMP_MAX and TEMP_MIN with no wrap.
REQ-024 EDIT: a set event SHALL load desired_temp from edit_temp and go to ACTIVE; temp_set SHALL rise on the same edge the state changes.
REQ-025 EDIT: a clear event SHALL go to OFF and discard edit_temp; desired_temp SHALL be unchanged.
REQ-026 EDIT: temp_set and desired_temp SHALL hold their pre-edit values until a commit or a clear.
REQ-027 EDIT: after TIMEOUT_CYCLES cycles with no event, the block SHALL return to the pre-edit state (OFF or ACTIVE) and discard edit_temp; every event SHALL restart the timer.
REQ-028 Simultaneous events SHALL resolve with priority clear > set > up/down; up and down events in the same cycle SHALL both be ignored.
REQ-029 Outside EDIT, edit_temp SHALL track desired_temp.
REQ-030 All outputs SHALL be registered; outputs update 1 cycle after the event pulse.

Reset
REQ-031 On reset: desired_temp=TEMP_DEFAULT, edit_temp=TEMP_DEFAULT, temp_set=0, editing=0, state=OFF, and all counters and synchronizers cleared.
REQ-032 Reset asserted mid-edit SHALL abandon the edit immediately, with no commit.

Structure
REQ-033 The shared package SHALL hold the state enum (OFF/EDIT/ACTIVE) and the TEMP_MIN/TEMP_MAX/TEMP_DEFAULT constants.
REQ-034 Synchronizer, debouncer and edge detector SHALL form one sub-module, btn_debounce, instantiated once per button.

Verification
Use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8 and TIMEOUT_CYCLES=64 for all scenarios.
REQ-035 Reset, then up pulse, up x3, set -> editing=1, edit_temp=73, then desired_temp=73 and temp_set=1 in ACTIVE.
REQ-036 Glitch on btn_up of 2 cycles -> no event, state unchanged.
REQ-037 From edit_temp=88, hold up for 40 cycles -> edit_temp saturates at 90, no wrap.
REQ-038 From ACTIVE at 73, down x2, then 64 idle cycles -> state returns to ACTIVE, desired_temp=73, edit_temp=73.
REQ-039 In EDIT, set and clear in the same cycle -> OFF, temp_set=0, desired_temp unchanged.
REQ-040 Reset asserted mid-EDIT at edit_temp=60 -> desired_temp=70, temp_set=0, state OFF.
